data_mem_bridge: RTL and testbench

Load/store bridge between the single-cycle datapath and an external word-wide data memory that has variable latency and a request/grant/valid handshake. It sits directly downstream of the datapath:

- **Consumes:** `ALUOut` (byte address) and `WriteData` (store data), plus the `MemWrite`/`MemRead` control bits.
- **Produces:** `ReadData` for the datapath's result mux, and a `stall` that freezes PC and register-file writes until the access completes.

It also flags misaligned addresses and memory timeouts.

---
 rtl/data_mem_bridge.sv | 110 +++++++++++
 tb/tb_data_mem_bridge.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bridge.sv
// rtl/data_mem_bridge.sv - load/store bridge from the datapath to a variable-latency word memory
// One access at a time: IDLE latches the request, REQ waits for grant, WAIT_R for read data, DONE commits.
module data_mem_bridge #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [31:0] ALUOut,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        stall,
   output logic        misalign,
   output logic        timeout,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_REQ    = 2'd1;
   localparam logic [1:0] S_WAIT_R = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      rd_reg;
   logic             we_q;
   logic [29:0]      addr_q;
   logic [31:0]      wdata_q;
   logic             tmo_q;

   logic request;
   logic aligned;
   logic cnt_hit;

   assign request = MemWrite | MemRead;
   assign aligned = (ALUOut[1:0] == 2'b00);
   assign cnt_hit = (cnt == TMO_CNT);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         rd_reg  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         tmo_q   <= 1'b0;
      end else begin
         // Counter saturates at TIMEOUT so a grant on the last REQ cycle leaves
         // WAIT_R exactly one cycle to see rvalid instead of wrapping around.
         if ((state == S_REQ || state == S_WAIT_R) && !cnt_hit) begin
            cnt <= cnt + 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (request && aligned) begin
                  addr_q  <= ALUOut[31:2];
                  wdata_q <= WriteData;
                  we_q    <= MemWrite;
                  cnt     <= '0;
                  state   <= S_REQ;
               end
            end
            S_REQ: begin
               if (mem_gnt) begin
                  state <= we_q ? S_DONE : S_WAIT_R;
               end else if (cnt_hit) begin
                  state  <= S_DONE;
                  tmo_q  <= 1'b1;
                  rd_reg <= '0;
               end
            end
            S_WAIT_R: begin
               if (mem_rvalid) begin
                  rd_reg <= mem_rdata;
                  state  <= S_DONE;
               end else if (cnt_hit) begin
                  state  <= S_DONE;
                  tmo_q  <= 1'b1;
                  rd_reg <= '0;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign misalign  = (state == S_IDLE) && request && !aligned;
   assign stall     = ((state == S_IDLE) && request && aligned) ||
                      (state == S_REQ) || (state == S_WAIT_R);
   assign ReadData  = misalign ? 32'h0 : rd_reg;
   assign timeout   = tmo_q;
   assign mem_req   = (state == S_REQ);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb/tb_data_mem_bridge.sv - randomized scoreboard bench for data_mem_bridge
module tb_data_mem_bridge;

   localparam int TMO = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite, MemRead;
   logic [31:0] ALUOut, WriteData, ReadData;
   logic        stall, misalign, timeout;
   logic        mem_req, mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   data_mem_bridge #(.TIMEOUT(TMO), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
      .ALUOut(ALUOut), .WriteData(WriteData), .ReadData(ReadData),
      .stall(stall), .misalign(misalign), .timeout(timeout),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          mis;
      logic [31:0] rdata;
      bit          tmo;
      int          stall_n;
      int          req_n;
      bit          we;
      logic [29:0] addr;
      logic [31:0] wdata;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem_model [logic [29:0]];
   logic [31:0] last_rd;
   bit          tmo_sticky;
   bit          mon_en = 1'b0;

   // Monitor: counts stall-high cycles per access and checks each completion.
   int   stall_run = 0;
   int   req_run   = 0;
   bit   req_seen  = 1'b0;
   exp_t me;

   always @(negedge clk) begin
      if (!mon_en) begin
         stall_run = 0;
         req_run   = 0;
         req_seen  = 1'b0;
      end else if (misalign) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_misalign", 32'd1, 32'd0);
         end else begin
            me = exp_q.pop_front();
            chk("mis_kind", 32'd1, 32'(me.mis));
            chk("mis_stall", 32'(stall), 32'd0);
            chk("mis_mem_req", 32'(mem_req), 32'd0);
            chk("mis_rdata", ReadData, 32'd0);
         end
      end else if (stall) begin
         stall_run++;
         if (mem_req) begin
            req_run++;
            if (!req_seen && exp_q.size() > 0) begin
               req_seen = 1'b1;
               chk("req_addr", 32'(mem_addr), 32'(exp_q[0].addr));
               chk("req_we", 32'(mem_we), 32'(exp_q[0].we));
               if (exp_q[0].we) chk("req_wdata", mem_wdata, exp_q[0].wdata);
            end
         end
      end else if (stall_run > 0) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            me = exp_q.pop_front();
            chk("done_kind", 32'(me.mis), 32'd0);
            chk("stall_cycles", 32'(stall_run), 32'(me.stall_n));
            chk("req_cycles", 32'(req_run), 32'(me.req_n));
            chk("done_rdata", ReadData, me.rdata);
            chk("done_timeout", 32'(timeout), 32'(me.tmo));
            chk("done_mem_req", 32'(mem_req), 32'd0);
         end
         stall_run = 0;
         req_run   = 0;
         req_seen  = 1'b0;
      end
   end

   // g: REQ cycles without grant before the grant; r: WAIT_R cycles before rvalid.
   task automatic access(input bit we, input bit rd, input logic [31:0] addr,
                         input logic [31:0] wdata, input int g, input int r);
      exp_t        e;
      int          ev, n;
      bit          ok;
      logic [31:0] rdata_v;
      e.mis   = (addr[1:0] != 2'b00);
      e.we    = we;
      e.addr  = addr[31:2];
      e.wdata = wdata;
      n       = 0;
      rdata_v = 32'h0;
      if (e.mis) begin
         e.rdata   = 32'h0;
         e.tmo     = tmo_sticky;
         e.stall_n = 0;
         e.req_n   = 0;
      end else begin
         ev = we ? g : g + 1 + r;
         ok = (ev <= TMO);
         n  = ok ? ev + 1 : TMO + 1;
         e.stall_n = n + 1;
         e.req_n   = (g <= TMO) ? g + 1 : TMO + 1;
         if (!mem_model.exists(addr[31:2])) mem_model[addr[31:2]] = $urandom;
         rdata_v = mem_model[addr[31:2]];
         if (!ok) begin
            last_rd    = 32'h0;
            tmo_sticky = 1'b1;
         end else if (we) begin
            mem_model[addr[31:2]] = wdata;
         end else begin
            last_rd = rdata_v;
         end
         e.rdata = last_rd;
         e.tmo   = tmo_sticky;
      end
      exp_q.push_back(e);
      MemWrite = we; MemRead = rd; ALUOut = addr; WriteData = wdata;
      @(posedge clk); #1;
      MemWrite = 1'b0; MemRead = 1'b0; ALUOut = $urandom; WriteData = $urandom;
      if (!e.mis) begin
         for (int k = 0; k < n; k++) begin
            mem_gnt    = (k == g);
            mem_rvalid = (!we && k == g + 1 + r) || (k <= g && $urandom_range(0, 1) == 1);
            mem_rdata  = (!we && k == g + 1 + r) ? rdata_v : $urandom;
            @(posedge clk); #1;
         end
         // Handshakes seen in DONE are stray and must not affect anything.
         mem_gnt    = 1'($urandom_range(0, 1));
         mem_rvalid = 1'b1;
         mem_rdata  = $urandom;
         @(posedge clk); #1;
         mem_gnt    = 1'b0;
         mem_rvalid = 1'b0;
      end
   endtask

   task automatic random_accesses(input int count);
      logic [31:0] a;
      bit          w, rd;
      for (int i = 0; i < count; i++) begin
         w  = 1'($urandom_range(0, 1));
         rd = !w || ($urandom_range(0, 1) == 1);
         a  = 32'($urandom_range(0, 63)) << 2;
         if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
         access(w, rd, a, $urandom, $urandom_range(0, 4), $urandom_range(0, 4));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b1; ALUOut = 32'h10; WriteData = 32'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      last_rd = 32'h0; tmo_sticky = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_rdata", ReadData, 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);

      @(posedge clk); #1;
      reset = 1'b1;
      mon_en = 1'b1;
      mem_model[30'h4] = 32'hCAFE_F00D;
      access(1'b0, 1'b1, 32'h10, 32'h0, 1, 2);
      access(1'b1, 1'b0, 32'h24, 32'h1234_5678, 0, 0);
      access(1'b0, 1'b1, 32'h13, 32'h0, 0, 0);
      random_accesses(40);

      access(1'b1, 1'b0, 32'h44, $urandom, 15, 0);
      access(1'b0, 1'b1, 32'h48, 32'h0, 2, 12);
      access(1'b0, 1'b1, 32'h4c, 32'h0, 2, 13);
      access(1'b0, 1'b1, 32'h50, 32'h0, 1, 100);
      access(1'b1, 1'b0, 32'h54, $urandom, 20, 0);
      drain();

      // Reset while waiting for read data.
      mon_en = 1'b0;
      MemRead = 1'b1; ALUOut = 32'h40;
      @(posedge clk); #1;
      MemRead = 1'b0; mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      @(negedge clk);
      chk("wait_r_stall", 32'(stall), 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("rstw_mem_req", 32'(mem_req), 32'd0);
      chk("rstw_stall", 32'(stall), 32'd0);
      chk("rstw_timeout", 32'(timeout), 32'd0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      @(negedge clk);
      chk("rstw_late_rvalid", ReadData, 32'd0);

      // Reset while requesting.
      @(posedge clk); #1;
      MemWrite = 1'b1; ALUOut = 32'h60; WriteData = 32'h5555_AAAA;
      @(posedge clk); #1;
      MemWrite = 1'b0;
      @(negedge clk);
      chk("req_mem_req", 32'(mem_req), 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1; mem_gnt = 1'b1;
      @(negedge clk);
      chk("rstr_mem_req", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      @(negedge clk);
      chk("rstr_late_gnt_req", 32'(mem_req), 32'd0);
      chk("rstr_late_gnt_stall", 32'(stall), 32'd0);

      @(posedge clk); #1;
      last_rd = 32'h0; tmo_sticky = 1'b0;
      mon_en = 1'b1;
      access(1'b1, 1'b1, 32'h80, 32'h0BAD_F00D, 0, 0);
      random_accesses(20);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
